// File: rtl/mskaes_128bits_round_ctrl_pkg.sv
// Shared definitions for the masked AES-128 round controller: FSM encoding,
// counter widths and the AES round-constant table.
package mskaes_128bits_round_ctrl_pkg;

    localparam int unsigned RndW    = 4;
    localparam int unsigned LastRnd = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone,
        StClean
    } state_e;

    // Width of the per-round cycle counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency > 1) ? unsigned'($clog2(latency)) : 1;
    endfunction

    // Round 0 and anything past round 10 map to zero so an idle round stage sees no constant.
    function automatic logic [7:0] rcon_lookup(input logic [RndW-1:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mskaes_128bits_round_ctrl_rcon_gen.sv
// Masked round constant: the public RCON sits in share 0 of every bit, the
// remaining shares are zero.
module mskaes_rcon_gen
    import mskaes_128bits_round_ctrl_pkg::*;
#(
    parameter int unsigned d = 2
) (
    input  logic [RndW-1:0]  rnd,
    output logic [8*d-1:0]   rnd_rcon
);

    logic [7:0] rcon_val;

    always_comb begin
        rcon_val = rcon_lookup(rnd);
        rnd_rcon = '0;
        for (int j = 0; j < 8; j++) begin
            rnd_rcon[j*d] = rcon_val[j];
        end
    end

endmodule

// File: rtl/mskaes_128bits_round_ctrl.sv
// Round controller for a masked AES-128 core: sequences ten rounds through an
// external round stage, delivers the shared ciphertext, then flushes the stage.
module mskaes_128bits_round_ctrl
    import mskaes_128bits_round_ctrl_pkg::*;
#(
    parameter int unsigned d       = 2,
    parameter int unsigned LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [128*d-1:0]   sh_plaintext,
    input  logic [128*d-1:0]   sh_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [128*d-1:0]   sh_ciphertext,
    output logic [128*d-1:0]   rnd_state,
    output logic [128*d-1:0]   rnd_key,
    output logic [8*d-1:0]     rnd_RCON,
    output logic               cleaning_on,
    input  logic [128*d-1:0]   rnd_state_out,
    input  logic [128*d-1:0]   rnd_key_out,
    input  logic [128*d-1:0]   rnd_state_SR_out,
    output logic               busy
);

    localparam int unsigned     CntW    = cnt_width(LATENCY);
    localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);
    localparam logic [RndW-1:0] RndLast = RndW'(LastRnd);

    state_e             state;
    logic [RndW-1:0]    rnd;
    logic [CntW-1:0]    cnt;
    logic [128*d-1:0]   state_reg;
    logic [128*d-1:0]   key_reg;
    logic [RndW-1:0]    rcon_rnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            rnd         <= '0;
            cnt         <= '0;
            state_reg   <= '0;
            key_reg     <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            cleaning_on <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        state_reg <= sh_plaintext ^ sh_key;
                        key_reg   <= sh_key;
                        rnd       <= RndW'(1);
                        cnt       <= '0;
                        state     <= StRound;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StRound: begin
                    cnt <= cnt + 1'b1;
                    // Round-stage inputs are held for LATENCY cycles; sample its outputs on the last.
                    if (cnt == CntLast) begin
                        key_reg <= rnd_key_out;
                        cnt     <= '0;
                        if (rnd == RndLast) begin
                            state_reg <= rnd_state_SR_out ^ rnd_key_out;
                            rnd       <= '0;
                            state     <= StDone;
                            out_valid <= 1'b1;
                        end else begin
                            state_reg <= rnd_state_out ^ rnd_key_out;
                            rnd       <= rnd + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state       <= StClean;
                        cnt         <= '0;
                        out_valid   <= 1'b0;
                        cleaning_on <= 1'b1;
                    end
                end
                StClean: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CntLast) begin
                        state_reg   <= '0;
                        key_reg     <= '0;
                        cnt         <= '0;
                        state       <= StIdle;
                        cleaning_on <= 1'b0;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Only an active round exposes state, key and constant to the round stage.
    assign rcon_rnd      = (state == StRound) ? rnd : '0;
    assign rnd_state     = (state == StRound) ? state_reg : '0;
    assign rnd_key       = (state == StRound) ? key_reg : '0;
    assign sh_ciphertext = out_valid ? state_reg : '0;

    mskaes_rcon_gen #(
        .d(d)
    ) u_rcon_gen (
        .rnd      (rcon_rnd),
        .rnd_rcon (rnd_RCON)
    );

endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
// Bench for the masked AES round controller with a behavioural, re-masking round
// stage and a ciphertext scoreboard.
module tb_mskaes_128bits_round_ctrl;

    localparam int unsigned D   = 2;
    localparam int unsigned LAT = 4;
    localparam int unsigned W   = 128 * D;
    localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [7:0] RconTab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                            8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready, out_valid, out_ready, cleaning_on, busy;
    logic [W-1:0]   sh_plaintext, sh_key, sh_ciphertext, rnd_state, rnd_key;
    logic [8*D-1:0] rnd_RCON;
    logic [W-1:0]   rnd_state_out = '0, rnd_key_out = '0, rnd_state_SR_out = '0;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [127:0] exp_q[$];

    mskaes_128bits_round_ctrl #(
        .d       (D),
        .LATENCY (LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .sh_plaintext     (sh_plaintext),
        .sh_key           (sh_key),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .sh_ciphertext    (sh_ciphertext),
        .rnd_state        (rnd_state),
        .rnd_key          (rnd_key),
        .rnd_RCON         (rnd_RCON),
        .cleaning_on      (cleaning_on),
        .rnd_state_out    (rnd_state_out),
        .rnd_key_out      (rnd_key_out),
        .rnd_state_SR_out (rnd_state_SR_out),
        .busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // Field inverse as b^254, then the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] t, inv;
        t = b; inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            t = gmul(t, t);
            inv = gmul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] v);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(v[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = v[127-32*c -: 8]; a1 = v[119-32*c -: 8];
            a2 = v[111-32*c -: 8]; a3 = v[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        logic [7:0] rc;
        s = pt ^ key; k = key; rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k = key_next(k, rc);
            s = (r == 10) ? (sub_shift(s) ^ k) : (mix(sub_shift(s)) ^ k);
            rc = xtime(rc);
        end
        return s;
    endfunction

    function automatic logic [W-1:0] mask128(input logic [127:0] v);
        logic [W-1:0] r;
        logic acc;
        for (int j = 0; j < 128; j++) begin
            acc = v[j];
            for (int s = 1; s < D; s++) begin
                r[j*D+s] = 1'($urandom_range(1, 0));
                acc = acc ^ r[j*D+s];
            end
            r[j*D] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] unmask128(input logic [W-1:0] v);
        logic [127:0] r;
        for (int j = 0; j < 128; j++) r[j] = ^v[j*D +: D];
        return r;
    endfunction

    function automatic logic [7:0] unmask8(input logic [8*D-1:0] v);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = ^v[j*D +: D];
        return r;
    endfunction

    function automatic logic hi_shares8(input logic [8*D-1:0] v);
        logic r;
        r = 1'b0;
        for (int j = 0; j < 8; j++)
            for (int s = 1; s < D; s++) r = r | v[j*D+s];
        return r;
    endfunction

    // Round stage: one register of latency, outputs freshly re-masked every cycle.
    always @(posedge clk) begin
        rnd_state_out    <= mask128(mix(sub_shift(unmask128(rnd_state))));
        rnd_state_SR_out <= mask128(sub_shift(unmask128(rnd_state)));
        rnd_key_out      <= mask128(key_next(unmask128(rnd_key), unmask8(rnd_RCON)));
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] exp, input string tag, output int e0);
        int t;
        sh_plaintext = mask128(pt);
        sh_key       = mask128(key);
        in_valid     = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_in_ready"}, W'(in_ready), W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        e0 = cyc;
        exp_q.push_back(exp);
    endtask

    task automatic run_enc(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input int hold, input bit pulse,
                           input string tag);
        int e0, ncl, t;
        logic [W-1:0] ct0, clean_or;
        start(pt, key, exp, tag, e0);
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 1) begin
                check($sformatf("%s_rcon_r%0d", tag, i / 4 + 1), W'(unmask8(rnd_RCON)),
                      W'(RconTab[i/4]));
                check($sformatf("%s_rcon_sh1_r%0d", tag, i / 4 + 1), W'(hi_shares8(rnd_RCON)),
                      '0);
            end
            if (pulse) begin
                in_valid = (i == 10);
                if (i == 10) sh_plaintext = mask128({4{$urandom}});
            end
            if (i == 39) check({tag, "_pre_valid"}, W'({out_valid, in_ready, busy}), W'(3'b001));
            @(negedge clk);
        end
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_latency"}, W'(cyc - e0), W'(10 * LAT));
        ct0 = sh_ciphertext;
        for (int h = 0; h < hold; h++) begin
            if (pulse) in_valid = (h == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            check({tag, "_hold_ct"}, sh_ciphertext, ct0);
            check({tag, "_hold_flags"}, W'({out_valid, in_ready}), W'(2'b10));
        end
        check({tag, "_rcon_done"}, W'(rnd_RCON), '0);
        check({tag, "_sb_size"}, W'(exp_q.size()), W'(1));
        if (exp_q.size() > 0) check({tag, "_ct"}, W'(unmask128(sh_ciphertext)), W'(exp_q.pop_front()));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ct_hidden"}, sh_ciphertext, '0);
        check({tag, "_clean_flags"}, W'({cleaning_on, out_valid}), W'(2'b10));
        ncl = 0;
        clean_or = '0;
        t = 0;
        while (!in_ready && t < 20) begin
            if (cleaning_on) ncl++;
            clean_or = clean_or | rnd_state;
            @(negedge clk);
            t++;
        end
        check({tag, "_clean_cycles"}, W'(ncl), W'(LAT));
        check({tag, "_clean_state"}, clean_or, '0);
        check({tag, "_regs_zero"}, dut.state_reg | dut.key_reg, '0);
        check({tag, "_idle_flags"}, W'({busy, cleaning_on, in_ready}), W'(3'b001));
    endtask

    initial begin
        int e0;
        logic [127:0] rpt, rkey;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sh_plaintext = '0;
        sh_key = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", W'({in_ready, out_valid, busy, cleaning_on}), '0);
        check("rst_data", sh_ciphertext | rnd_state | rnd_key, '0);
        check("rst_rcon", W'(rnd_RCON), '0);
        check("rst_regs", dut.state_reg | dut.key_reg, '0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_low", W'(in_ready), '0);
        @(negedge clk);
        check("rel_ready_high", W'(in_ready), W'(1));

        run_enc(FipsPt, FipsKey, FipsCt, 20, 1'b0, "fips_bp");
        run_enc(FipsPt, FipsKey, FipsCt, 2, 1'b1, "ignore_iv");

        start(FipsPt, FipsKey, FipsCt, "abort", e0);
        while (cyc < e0 + 17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", W'({in_ready, out_valid, busy, cleaning_on}), '0);
        check("abort_data", sh_ciphertext | rnd_state | rnd_key, '0);
        check("abort_rcon", W'(rnd_RCON), '0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_valid", W'(out_valid), '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_enc(FipsPt, FipsKey, FipsCt, 0, 1'b0, "post_rst");
        run_enc(FipsPt, FipsKey, FipsCt, 0, 1'b0, "b2b_a");
        run_enc(FipsPt, FipsKey, FipsCt, 0, 1'b0, "b2b_b");
        rpt  = {$urandom, $urandom, $urandom, $urandom};
        rkey = {$urandom, $urandom, $urandom, $urandom};
        run_enc(rpt, rkey, aes_enc(rpt, rkey), 1, 1'b0, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
